// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared width and state encoding for pipe_stage_reg
package pipe_stage_reg_pkg;

    // Default payload width: final_a/final_b/control fields bundled together.
    localparam int PSR_DATA_W = 64;

    // Encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } psr_state_e;

    // Number of held entries for a given state.
    function automatic logic [1:0] psr_occupancy(input psr_state_e st);
        case (st)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid-buffered pipeline register with flush
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = PSR_DATA_W,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    psr_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q;
    logic              in_fire;
    logic              out_fire;

    // Handshake outputs come from registered state only; rdy_q holds
    // in_ready low while reset is asserted and releases on the first edge.
    always_comb begin
        in_ready  = rdy_q && (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
        out_data  = main_q;
        occupancy = psr_occupancy(state_q);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // Next state and register loads; flush empties the stage but leaves data alone.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            skid_d  = in_data;
                            state_d = ST_FULL;
                        end
                        2'b01: begin
                            state_d = ST_EMPTY;
                        end
                        2'b11: begin
                            main_d = in_data;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and ready flag; reset drops all entries asynchronously.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    // Payload registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            main_q <= RESET_DATA;
            skid_q <= RESET_DATA;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboard checks for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int W = 64;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb_q[$];

    pipe_stage_reg #(.DATA_W(W), .RESET_DATA('0)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic iv, orr, exp_ir, exp_ov, fl;
        logic [W-1:0] d;

        sys_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #3;
        chk("rst_in_ready", W'(in_ready), 0);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_occ", W'(occupancy), 0);
        chk("rst_out_data", out_data, 0);
        tick(); tick();
        sys_rst = 1'b1;
        tick();
        chk("post_rst_in_ready", W'(in_ready), 1);

        // single push
        in_valid = 1'b1; in_data = 64'h11; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("push_out_valid", W'(out_valid), 1);
        chk("push_out_data", out_data, 64'h11);
        chk("push_occ1", W'(occupancy), 1);
        tick();
        chk("push_occ0", W'(occupancy), 0);
        chk("push_out_valid0", W'(out_valid), 0);

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
        tick();
        in_data = 64'hB;
        tick();
        chk("bp_occ2", W'(occupancy), 2);
        chk("bp_in_ready0", W'(in_ready), 0);
        in_data = 64'hC;
        tick();
        chk("bp_hold_occ", W'(occupancy), 2);
        chk("bp_hold_data", out_data, 64'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_second", out_data, 64'hB);
        chk("bp_occ1", W'(occupancy), 1);
        tick();
        chk("bp_drained", W'(occupancy), 0);

        // streaming
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 64'h100 + W'(i);
            tick();
            chk("stream_data", out_data, 64'h100 + W'(i));
            chk("stream_in_ready", W'(in_ready), 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_done", W'(occupancy), 0);

        // flush while full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1;
        tick();
        in_data = 64'h2;
        tick();
        chk("fl_full", W'(occupancy), 2);
        in_data = 64'h3; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ0", W'(occupancy), 0);
        chk("fl_out_valid0", W'(out_valid), 0);
        tick();
        chk("fl_still_empty", W'(out_valid), 0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h4;
        tick();
        in_valid = 1'b0;
        chk("fl_next_data", out_data, 64'h4);
        tick();

        // async reset mid-cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
        tick();
        in_data = 64'h66;
        tick();
        in_valid = 1'b0;
        #2 sys_rst = 1'b0;
        #1;
        chk("ar_out_valid", W'(out_valid), 0);
        chk("ar_occ", W'(occupancy), 0);
        chk("ar_in_ready", W'(in_ready), 0);
        chk("ar_out_data", out_data, 0);
        #2 sys_rst = 1'b1;
        tick();
        chk("ar_in_ready1", W'(in_ready), 1);
        chk("ar_empty", W'(out_valid), 0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h77;
        tick();
        in_valid = 1'b0;
        chk("ar_resume", out_data, 64'h77);
        tick();
        chk("ar_resume_empty", W'(occupancy), 0);

        // random valid/ready/flush against a queue model
        sb_q.delete();
        for (int c = 0; c < 3000; c++) begin
            iv  = 1'($urandom_range(0, 1));
            orr = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 63) == 0);
            d   = {$urandom(), $urandom()};
            in_valid = iv; out_ready = orr; flush = fl; in_data = d;
            #1;
            exp_ir = (sb_q.size() < 2);
            exp_ov = (sb_q.size() != 0);
            chk("rnd_in_ready", W'(in_ready), W'(exp_ir));
            chk("rnd_out_valid", W'(out_valid), W'(exp_ov));
            chk("rnd_occ", W'(occupancy), W'(sb_q.size()));
            if (exp_ov) chk("rnd_order", out_data, sb_q[0]);
            if (fl) begin
                sb_q.delete();
            end else begin
                if (exp_ov && orr) void'(sb_q.pop_front());
                if (exp_ir && iv) sb_q.push_back(d);
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
